// File: rtl/seq_trojan_trigger.sv
// Sequential trojan: counts masked rare-value matches on trig_nets and, at THRESH, XOR-corrupts the victim bus.
// victim_out is a zero-latency passthrough except while the registered state is ARMED with trojan_en high.
module seq_trojan_trigger #(
   parameter int                 WIDTH        = 7,
   parameter int                 TRIG_W       = 2,
   parameter logic [TRIG_W-1:0]  TRIG_VAL     = 2'b11,
   parameter logic [TRIG_W-1:0]  TRIG_MASK    = 2'b11,
   parameter logic [WIDTH-1:0]   VICTIM_MASK  = 7'b0001000,
   parameter int                 THRESH       = 4,
   parameter int                 CNT_W        = 4,
   parameter int                 CONSEC       = 0,
   parameter int                 PAYLOAD_MODE = 0,
   parameter int                 PULSE_LEN    = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trojan_en,
   input  logic [TRIG_W-1:0] trig_nets,
   input  logic [WIDTH-1:0]  victim_in,
   output logic [WIDTH-1:0]  victim_out,
   output logic              armed,
   output logic [CNT_W-1:0]  trig_count,
   output logic              fire_pulse
);

   localparam int               PW   = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [CNT_W-1:0] THR  = CNT_W'(THRESH);
   localparam logic [PW-1:0]    PEND = PW'(PULSE_LEN - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNT    = 2'd1,
      ARMED    = 2'd2,
      COOLDOWN = 2'd3
   } state_t;

   state_t           state;
   logic [PW-1:0]    pulse_cnt;
   logic             match;
   logic [CNT_W-1:0] cnt_inc;

   assign match   = ((trig_nets & TRIG_MASK) == (TRIG_VAL & TRIG_MASK)) && trojan_en;
   assign cnt_inc = trig_count + CNT_W'(1);

   // Payload gated by rst_n and trojan_en so both give an immediate golden output.
   assign victim_out = (rst_n && trojan_en && (state == ARMED)) ? (victim_in ^ VICTIM_MASK)
                                                               : victim_in;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         trig_count <= '0;
         pulse_cnt  <= '0;
         armed      <= 1'b0;
         fire_pulse <= 1'b0;
      end else if (!trojan_en) begin
         state      <= IDLE;
         trig_count <= '0;
         pulse_cnt  <= '0;
         armed      <= 1'b0;
         fire_pulse <= 1'b0;
      end else begin
         fire_pulse <= 1'b0;
         case (state)
            IDLE: begin
               if (match) begin
                  trig_count <= CNT_W'(1);
                  if (THRESH == 1) begin
                     state      <= ARMED;
                     armed      <= 1'b1;
                     fire_pulse <= 1'b1;
                     pulse_cnt  <= '0;
                  end else begin
                     state <= COUNT;
                  end
               end
            end
            COUNT: begin
               if (match) begin
                  trig_count <= cnt_inc;
                  if (cnt_inc == THR) begin
                     state      <= ARMED;
                     armed      <= 1'b1;
                     fire_pulse <= 1'b1;
                     pulse_cnt  <= '0;
                  end
               end else if (CONSEC != 0) begin
                  trig_count <= '0;
                  state      <= IDLE;
               end
            end
            ARMED: begin
               // Pulse mode holds the payload for PULSE_LEN cycles, then cools down and re-arms from zero.
               if (PAYLOAD_MODE != 0) begin
                  if (pulse_cnt == PEND) begin
                     state      <= COOLDOWN;
                     armed      <= 1'b0;
                     trig_count <= '0;
                     pulse_cnt  <= '0;
                  end else begin
                     pulse_cnt <= pulse_cnt + PW'(1);
                  end
               end
            end
            COOLDOWN: begin
               state      <= IDLE;
               trig_count <= '0;
            end
            default: begin
               state      <= IDLE;
               trig_count <= '0;
               armed      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_trojan_trigger.sv
// Directed bench for seq_trojan_trigger: default, consecutive, pulse-payload and THRESH=1 configurations.
module tb_seq_trojan_trigger;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // per-instance stimulus
   logic       rst0, en0, rst1, en1, rst2, en2, rst3, en3;
   logic [1:0] trig0, trig1, trig2, trig3;
   logic [6:0] vin0, vin1, vin2, vin3;
   logic [6:0] out0, out1, out2, out3;
   logic       arm0, arm1, arm2, arm3;
   logic [3:0] cnt0, cnt1, cnt2, cnt3;
   logic       fire0, fire1, fire2, fire3;

   seq_trojan_trigger u0 (
      .clk(clk), .rst_n(rst0), .trojan_en(en0), .trig_nets(trig0), .victim_in(vin0),
      .victim_out(out0), .armed(arm0), .trig_count(cnt0), .fire_pulse(fire0));

   seq_trojan_trigger #(.CONSEC(1)) u1 (
      .clk(clk), .rst_n(rst1), .trojan_en(en1), .trig_nets(trig1), .victim_in(vin1),
      .victim_out(out1), .armed(arm1), .trig_count(cnt1), .fire_pulse(fire1));

   seq_trojan_trigger #(.PAYLOAD_MODE(1), .PULSE_LEN(2)) u2 (
      .clk(clk), .rst_n(rst2), .trojan_en(en2), .trig_nets(trig2), .victim_in(vin2),
      .victim_out(out2), .armed(arm2), .trig_count(cnt2), .fire_pulse(fire2));

   seq_trojan_trigger #(.THRESH(1), .TRIG_MASK(2'b01)) u3 (
      .clk(clk), .rst_n(rst3), .trojan_en(en3), .trig_nets(trig3), .victim_in(vin3),
      .victim_out(out3), .armed(arm3), .trig_count(cnt3), .fire_pulse(fire3));

   typedef struct packed {
      logic       rst;
      logic       en;
      logic [1:0] trig;
      logic [6:0] vin;
      logic [6:0] e_out;
      logic       e_armed;
      logic [3:0] e_cnt;
      logic       e_fire;
   } vec_t;

   vec_t vecs[24];
   int   total = 0;
   int   bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_row(input int i);
      @(negedge clk);
      rst0 = vecs[i].rst; en0 = vecs[i].en; trig0 = vecs[i].trig; vin0 = vecs[i].vin;
      tick();
      chk($sformatf("u0 row%0d out", i),   32'(out0),  32'(vecs[i].e_out));
      chk($sformatf("u0 row%0d armed", i), 32'(arm0),  32'(vecs[i].e_armed));
      chk($sformatf("u0 row%0d cnt", i),   32'(cnt0),  32'(vecs[i].e_cnt));
      chk($sformatf("u0 row%0d fire", i),  32'(fire0), 32'(vecs[i].e_fire));
   endtask

   // u1 (CONSEC=1): matches on 1-3, gap on 4, matches on 5-8
   logic [1:0] c_trig [8] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b11, 2'b11};
   int         c_cnt  [8] = '{1, 2, 3, 0, 1, 2, 3, 4};
   int         c_arm  [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
   // u2 (pulse mode): trig held at 11 for 11 edges
   int         p_cnt  [11] = '{1, 2, 3, 4, 4, 0, 0, 1, 2, 3, 4};
   int         p_arm  [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1};
   int         p_fire [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

   initial begin
      //          rst   en    trig   vin    e_out  arm   cnt   fire
      vecs[0]  = '{1'b0, 1'b1, 2'b00, 7'h55, 7'h55, 1'b0, 4'd0, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 2'b00, 7'h55, 7'h55, 1'b0, 4'd1, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd2, 1'b0};
      vecs[4]  = '{1'b1, 1'b1, 2'b00, 7'h55, 7'h55, 1'b0, 4'd2, 1'b0};
      vecs[5]  = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd3, 1'b0};
      vecs[6]  = '{1'b1, 1'b1, 2'b00, 7'h55, 7'h55, 1'b0, 4'd3, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h5D, 1'b1, 4'd4, 1'b1};
      vecs[8]  = '{1'b1, 1'b1, 2'b00, 7'h55, 7'h5D, 1'b1, 4'd4, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 2'b11, 7'h7F, 7'h77, 1'b1, 4'd4, 1'b0};
      vecs[10] = '{1'b1, 1'b1, 2'b10, 7'h00, 7'h08, 1'b1, 4'd4, 1'b0};
      // enable drop, count to 3, enable drop on the would-be arming match, re-arm, resets
      vecs[11] = '{1'b1, 1'b0, 2'b11, 7'h55, 7'h55, 1'b0, 4'd0, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd1, 1'b0};
      vecs[13] = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd2, 1'b0};
      vecs[14] = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd3, 1'b0};
      vecs[15] = '{1'b1, 1'b0, 2'b11, 7'h55, 7'h55, 1'b0, 4'd0, 1'b0};
      vecs[16] = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd1, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd2, 1'b0};
      vecs[18] = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd3, 1'b0};
      vecs[19] = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h5D, 1'b1, 4'd4, 1'b1};
      vecs[20] = '{1'b0, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd0, 1'b0};
      vecs[21] = '{1'b1, 1'b1, 2'b00, 7'h2A, 7'h2A, 1'b0, 4'd0, 1'b0};
      vecs[22] = '{1'b0, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd0, 1'b0};
      vecs[23] = '{1'b1, 1'b1, 2'b11, 7'h55, 7'h55, 1'b0, 4'd1, 1'b0};

      rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
      en0 = 1'b1; en1 = 1'b1; en2 = 1'b1; en3 = 1'b1;
      trig0 = 2'b00; trig1 = 2'b00; trig2 = 2'b00; trig3 = 2'b00;
      vin0 = 7'h55; vin1 = 7'h55; vin2 = 7'h55; vin3 = 7'h55;
      tick();
      tick();
      chk("u1 reset armed", 32'(arm1), 32'd0);
      chk("u2 reset cnt",   32'(cnt2), 32'd0);
      chk("u3 reset fire",  32'(fire3), 32'd0);
      @(negedge clk);
      rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;

      // default config: cumulative, persistent
      for (int i = 0; i <= 10; i++) run_row(i);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         trig0 = 2'($urandom_range(0, 3));
         vin0  = 7'h55;
         tick();
         chk($sformatf("u0 persist%0d out", k), 32'(out0), 32'h5D);
         chk($sformatf("u0 persist%0d armed", k), 32'(arm0), 32'd1);
      end
      for (int i = 11; i <= 23; i++) run_row(i);

      // consecutive mode
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         trig1 = c_trig[i];
         tick();
         chk($sformatf("u1 step%0d cnt", i),   32'(cnt1), 32'(c_cnt[i]));
         chk($sformatf("u1 step%0d armed", i), 32'(arm1), 32'(c_arm[i]));
         chk($sformatf("u1 step%0d out", i),   32'(out1), (c_arm[i] != 0) ? 32'h5D : 32'h55);
      end
      chk("u1 fire", 32'(fire1), 32'd1);

      // pulse payload, cooldown, re-arm
      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         trig2 = 2'b11;
         tick();
         chk($sformatf("u2 step%0d cnt", i),   32'(cnt2),  32'(p_cnt[i]));
         chk($sformatf("u2 step%0d armed", i), 32'(arm2),  32'(p_arm[i]));
         chk($sformatf("u2 step%0d fire", i),  32'(fire2), 32'(p_fire[i]));
         chk($sformatf("u2 step%0d out", i),   32'(out2),  (p_arm[i] != 0) ? 32'h5D : 32'h55);
      end

      // THRESH=1 with bit0-only mask
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         trig3 = 2'b10;
         tick();
         chk($sformatf("u3 nomatch%0d armed", i), 32'(arm3), 32'd0);
         chk($sformatf("u3 nomatch%0d cnt", i),   32'(cnt3), 32'd0);
      end
      @(negedge clk);
      trig3 = 2'b01;
      tick();
      chk("u3 armed", 32'(arm3),  32'd1);
      chk("u3 cnt",   32'(cnt3),  32'd1);
      chk("u3 fire",  32'(fire3), 32'd1);
      chk("u3 out",   32'(out3),  32'h5D);

      // golden circuit with the trojan disabled
      for (int k = 0; k < 10000; k++) begin
         @(negedge clk);
         en0   = 1'b0;
         trig0 = 2'($urandom_range(0, 3));
         vin0  = 7'($urandom_range(0, 127));
         tick();
         if ((out0 !== vin0) || (arm0 !== 1'b0) || (cnt0 !== 4'd0)) begin
            chk($sformatf("golden%0d out", k),   32'(out0), 32'(vin0));
            chk($sformatf("golden%0d armed", k), 32'(arm0), 32'd0);
            chk($sformatf("golden%0d cnt", k),   32'(cnt0), 32'd0);
         end else begin
            total++;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
